// File: rtl/imm_gen_pipe.sv
// Buffered RV32/RV64 immediate generator: decodes I/S/B/U/J immediates at enqueue
// into a DEPTH-entry FIFO. Optional feature macro: IMM_SHAMT_EN (zero-extended shamt).
module imm_gen_pipe #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] FMT_I    = 3'd0;
  localparam logic [2:0] FMT_S    = 3'd1;
  localparam logic [2:0] FMT_B    = 3'd2;
  localparam logic [2:0] FMT_U    = 3'd3;
  localparam logic [2:0] FMT_J    = 3'd4;
  localparam logic [2:0] FMT_NONE = 3'd7;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          dec;
  entry_t          head;
  logic [63:0]     wide;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;

  function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Immediate decode; computed 64 bits wide, then truncated to XLEN
  always_comb begin
    wide        = '0;
    dec         = '0;
    dec.fmt     = FMT_I;
    dec.illegal = 1'b0;
    case (inst[6:0])
      OP_LOAD, OP_JALR: wide = {{52{inst[31]}}, inst[31:20]};
      OP_IMM: begin
        wide = {{52{inst[31]}}, inst[31:20]};
`ifdef IMM_SHAMT_EN
        if (inst[13:12] == 2'b01)
          wide = (XLEN == 64) ? {58'b0, inst[25:20]} : {59'b0, inst[24:20]};
`endif
      end
      OP_IMM32: begin
        if (XLEN == 64) begin
          wide = {{52{inst[31]}}, inst[31:20]};
`ifdef IMM_SHAMT_EN
          if (inst[13:12] == 2'b01) wide = {59'b0, inst[24:20]};
`endif
        end else begin
          dec.fmt     = FMT_NONE;
          dec.illegal = 1'b1;
        end
      end
      OP_STORE: begin
        wide    = {{52{inst[31]}}, inst[31:25], inst[11:7]};
        dec.fmt = FMT_S;
      end
      OP_BRANCH: begin
        wide    = {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
        dec.fmt = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        wide    = {{32{inst[31]}}, inst[31:12], 12'b0};
        dec.fmt = FMT_U;
      end
      OP_JAL: begin
        wide    = {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
        dec.fmt = FMT_J;
      end
      default: begin
        dec.fmt     = FMT_NONE;
        dec.illegal = 1'b1;
      end
    endcase
    dec.imm = wide[XLEN-1:0];
  end

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Circular buffer; flush wins over push/pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (flush) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= dec;
        wr_ptr      <= nxt_ptr(wr_ptr);
      end
      if (pop) rd_ptr <= nxt_ptr(rd_ptr);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Outputs forced to zero while the buffer is empty
  assign head        = out_valid ? mem[rd_ptr] : '0;
  assign out_imm     = head.imm;
  assign out_fmt     = head.fmt;
  assign out_illegal = head.illegal;

endmodule
